led_arbiter_sched: RTL and testbench

//  Shares the single board LED between NREQ status requesters and sequences its PWM brightness.

---
 rtl/led_arbiter_sched.sv | 254 +++++++++++++++++++++++++
 tb/tb_led_arbiter_sched.sv | 216 +++++++++++++++++++++
 2 files changed

// File: rtl/led_arbiter_sched.sv
// rtl/led_arbiter_sched.sv - frame-synchronous LED owner arbiter with PWM pattern sequencer
//
// Shares one LED between NREQ requesters. Arbitration and pattern updates happen
// only on PWM frame boundaries, so the LED never glitches mid-frame.
//
// Ports:
//   clk         system clock
//   rst_n       asynchronous reset, active low
//   req         per-requester request level (highest index = highest priority)
//   req_mode    2-bit mode per requester at [2i+1:2i]: 0 OFF, 1 ON, 2 BLINK, 3 BREATH
//   grant       one-hot current owner, zero when idle
//   cur_mode    mode being displayed, zero when idle
//   frame_tick  one-cycle pulse marking the PWM frame wrap
//   led_out     registered PWM drive for the LED pad
module led_arbiter_sched #(
  parameter int NREQ               = 3,
  parameter int PWM_BITS           = 8,
  parameter int CLK_DIV            = 105,
  parameter int MIN_HOLD           = 8,
  parameter int BLINK_FRAMES       = 250,
  parameter int BREATH_STEP_FRAMES = 2
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic [NREQ-1:0]     req,
  input  logic [2*NREQ-1:0]   req_mode,
  output logic [NREQ-1:0]     grant,
  output logic [1:0]          cur_mode,
  output logic                frame_tick,
  output logic                led_out
);

  localparam int PSW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam int IW  = (NREQ > 1) ? $clog2(NREQ) : 1;
  localparam int HW  = $clog2(MIN_HOLD + 1);
  localparam int BW  = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;
  localparam int SW  = (BREATH_STEP_FRAMES > 1) ? $clog2(BREATH_STEP_FRAMES) : 1;

  localparam logic [PSW-1:0]      PRESC_LAST = PSW'(CLK_DIV - 1);
  localparam logic [PWM_BITS-1:0] DUTY_MAX   = '1;
  localparam logic [HW-1:0]       HOLD_MAX   = HW'(MIN_HOLD);
  localparam logic [BW-1:0]       BLINK_LAST = BW'(BLINK_FRAMES - 1);
  localparam logic [SW-1:0]       STEP_LAST  = SW'(BREATH_STEP_FRAMES - 1);

  localparam logic [1:0] M_OFF    = 2'd0;
  localparam logic [1:0] M_ON     = 2'd1;
  localparam logic [1:0] M_BLINK  = 2'd2;
  localparam logic [1:0] M_BREATH = 2'd3;

  typedef enum logic {S_IDLE, S_GRANTED} state_t;

  // ---------------------------------------------------------------- timebase
  logic [PSW-1:0]      presc;
  logic [PWM_BITS-1:0] pwm_cnt;
  logic                tick;

  assign tick = (presc == PRESC_LAST);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      presc      <= '0;
      pwm_cnt    <= '0;
      frame_tick <= 1'b0;
    end else begin
      presc <= tick ? '0 : presc + 1'b1;
      if (tick) pwm_cnt <= pwm_cnt + 1'b1;
      // Registered so it is high in the first clock of the new frame; every
      // frame-boundary decision below is taken on the edge that ends this clock.
      frame_tick <= tick && (pwm_cnt == DUTY_MAX);
    end
  end

  // ------------------------------------------------------------ arbitration
  state_t          state, nxt_state;
  logic [IW-1:0]   owner, nxt_owner;
  logic [HW-1:0]   hold_cnt, nxt_hold;
  logic [IW-1:0]   top_idx;
  logic            any_req;
  logic            owner_req;
  logic [NREQ-1:0] nxt_grant;
  logic [1:0]      nxt_mode;

  // Priority encoder: ascending scan so the highest set index wins.
  always_comb begin
    any_req   = |req;
    top_idx   = '0;
    owner_req = 1'b0;
    for (int i = 0; i < NREQ; i++) begin
      if (req[i]) top_idx = IW'(i);
      if (owner == IW'(i)) owner_req = req[i];
    end
  end

  always_comb begin
    nxt_state = state;
    nxt_owner = owner;
    nxt_hold  = hold_cnt;
    if (frame_tick) begin
      case (state)
        S_IDLE: begin
          if (any_req) begin
            nxt_state = S_GRANTED;
            nxt_owner = top_idx;
            nxt_hold  = '0;
          end
        end
        S_GRANTED: begin
          if (!owner_req) begin
            // Owner let go: hand over at once, hold time does not apply.
            nxt_hold = '0;
            if (any_req) begin
              nxt_owner = top_idx;
            end else begin
              nxt_state = S_IDLE;
              nxt_owner = '0;
            end
          end else if ((top_idx > owner) && (hold_cnt == HOLD_MAX)) begin
            nxt_owner = top_idx;
            nxt_hold  = '0;
          end else if (hold_cnt != HOLD_MAX) begin
            nxt_hold = hold_cnt + 1'b1;
          end
        end
        default: begin
          nxt_state = S_IDLE;
          nxt_owner = '0;
          nxt_hold  = '0;
        end
      endcase
    end
  end

  // Decode the owner chosen for the coming frame and sample its mode.
  always_comb begin
    nxt_grant = '0;
    nxt_mode  = M_OFF;
    if (nxt_state == S_GRANTED) begin
      for (int i = 0; i < NREQ; i++) begin
        if (nxt_owner == IW'(i)) begin
          nxt_grant[i] = 1'b1;
          nxt_mode     = req_mode[2*i +: 2];
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= S_IDLE;
      owner    <= '0;
      hold_cnt <= '0;
      grant    <= '0;
      cur_mode <= M_OFF;
    end else begin
      state    <= nxt_state;
      owner    <= nxt_owner;
      hold_cnt <= nxt_hold;
      if (frame_tick) begin
        grant    <= nxt_grant;
        cur_mode <= nxt_mode;
      end
    end
  end

  // ------------------------------------------------------- pattern sequencer
  logic                restart;
  logic                blink_on, nxt_blink_on;
  logic [BW-1:0]       blink_cnt, nxt_blink_cnt;
  logic [SW-1:0]       step_cnt, nxt_step_cnt;
  logic                dir_up, nxt_dir_up;
  logic [PWM_BITS-1:0] duty, nxt_duty;

  // Any change of owner or displayed mode starts the pattern from its origin.
  assign restart = (nxt_grant != grant) || (nxt_mode != cur_mode);

  always_comb begin
    nxt_blink_on  = blink_on;
    nxt_blink_cnt = blink_cnt;
    nxt_step_cnt  = step_cnt;
    nxt_dir_up    = dir_up;
    nxt_duty      = duty;
    if (restart) begin
      nxt_blink_on  = 1'b1;
      nxt_blink_cnt = '0;
      nxt_step_cnt  = '0;
      nxt_dir_up    = 1'b1;
      nxt_duty      = (nxt_mode == M_BLINK) ? DUTY_MAX : '0;
    end else begin
      case (cur_mode)
        M_BLINK: begin
          if (blink_cnt == BLINK_LAST) begin
            nxt_blink_cnt = '0;
            nxt_blink_on  = !blink_on;
          end else begin
            nxt_blink_cnt = blink_cnt + 1'b1;
          end
          nxt_duty = nxt_blink_on ? DUTY_MAX : '0;
        end
        M_BREATH: begin
          if (step_cnt == STEP_LAST) begin
            nxt_step_cnt = '0;
            // Turn around at the rails so the triangle never wraps.
            if (dir_up) begin
              if (duty == DUTY_MAX) begin
                nxt_duty   = duty - 1'b1;
                nxt_dir_up = 1'b0;
              end else begin
                nxt_duty = duty + 1'b1;
              end
            end else begin
              if (duty == '0) begin
                nxt_duty   = duty + 1'b1;
                nxt_dir_up = 1'b1;
              end else begin
                nxt_duty = duty - 1'b1;
              end
            end
          end else begin
            nxt_step_cnt = step_cnt + 1'b1;
          end
        end
        default: nxt_duty = '0;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      blink_on  <= 1'b1;
      blink_cnt <= '0;
      step_cnt  <= '0;
      dir_up    <= 1'b1;
      duty      <= '0;
    end else if (frame_tick) begin
      blink_on  <= nxt_blink_on;
      blink_cnt <= nxt_blink_cnt;
      step_cnt  <= nxt_step_cnt;
      dir_up    <= nxt_dir_up;
      duty      <= nxt_duty;
    end
  end

  // ------------------------------------------------------------- LED output
  // duty never exceeds 2^PWM_BITS-1, so non-ON modes top out one tick short
  // of fully on; ON bypasses the comparator.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      led_out <= 1'b0;
    end else begin
      led_out <= (cur_mode == M_ON) || ((state == S_GRANTED) && (pwm_cnt < duty));
    end
  end

endmodule

// File: tb/tb_led_arbiter_sched.sv
// tb/tb_led_arbiter_sched.sv - scoreboard bench for led_arbiter_sched
module tb_led_arbiter_sched;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [2:0] req = '0;
  logic [5:0] req_mode = '0;
  logic [2:0] grant;
  logic [1:0] cur_mode;
  logic       frame_tick;
  logic       led_out;

  int checks = 0;
  int failures = 0;

  typedef struct {
    int         frame;
    logic [2:0] g;
    logic [1:0] m;
    int         highs;
  } exp_t;

  exp_t exp_q[$];

  int         fcount = 0;
  int         hcnt = 0;
  int         cyc = 0;
  int         last_tick = -1;
  logic       ft_prev = 1'b0;
  logic [2:0] g_cur = '0;
  logic [1:0] m_cur = '0;

  int breath_exp[32] = '{0, 1, 2, 3, 4, 5, 6, 7, 8, 9, 10, 11, 12, 13, 14, 15,
                         14, 13, 12, 11, 10, 9, 8, 7, 6, 5, 4, 3, 2, 1, 0, 1};

  led_arbiter_sched #(
    .NREQ(3), .PWM_BITS(4), .CLK_DIV(2), .MIN_HOLD(2),
    .BLINK_FRAMES(3), .BREATH_STEP_FRAMES(1)
  ) dut (
    .clk(clk), .rst_n(rst_n), .req(req), .req_mode(req_mode),
    .grant(grant), .cur_mode(cur_mode), .frame_tick(frame_tick), .led_out(led_out)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input int act, input int expv);
    checks++;
    if (act != expv) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d", name, act, expv);
    end
  endtask

  function automatic void push(input int f, input logic [2:0] g, input logic [1:0] m, input int h);
    exp_t e;
    e.frame = f; e.g = g; e.m = m; e.highs = h;
    exp_q.push_back(e);
  endfunction

  task automatic finalize(input int k, input logic [2:0] g, input logic [1:0] m, input int h);
    exp_t e;
    while (exp_q.size() > 0 && exp_q[0].frame < k) begin
      e = exp_q.pop_front();
      chk($sformatf("missed_frame_%0d", e.frame), k, e.frame);
    end
    if (exp_q.size() > 0 && exp_q[0].frame == k) begin
      e = exp_q.pop_front();
      chk($sformatf("grant_f%0d", k), int'(g), int'(e.g));
      chk($sformatf("mode_f%0d", k), int'(m), int'(e.m));
      if (e.highs >= 0) chk($sformatf("highs_f%0d", k), h, e.highs);
    end
  endtask

  // Monitor: a frame's LED window runs from 2 clocks after frame_tick to 1
  // clock after the next one, which lines up with the registered duty/led path.
  always @(negedge clk) begin
    if (!rst_n) begin
      fcount = 0; hcnt = 0; cyc = 0; last_tick = -1;
      ft_prev = 1'b0; g_cur = '0; m_cur = '0;
    end else begin
      cyc++;
      hcnt += int'(led_out);
      if (ft_prev) begin
        finalize(fcount, g_cur, m_cur, hcnt);
        fcount++;
        g_cur = grant;
        m_cur = cur_mode;
        hcnt = 0;
      end
      if (frame_tick) begin
        if (last_tick >= 0) chk("tick_interval", cyc - last_tick, 32);
        last_tick = cyc;
      end
      ft_prev = frame_tick;
    end
  end

  task automatic wait_frame(input int n);
    int t = 0;
    while (fcount < n && t < 4000) begin
      @(posedge clk);
      t++;
    end
    if (fcount < n) chk($sformatf("wait_frame_%0d_timeout", n), fcount, n);
  endtask

  task automatic mid_frame();
    repeat (10) @(posedge clk);
    #2;
  endtask

  task automatic set_req(input int i, input logic v, input logic [1:0] m);
    req[i] = v;
    req_mode[2*i +: 2] = m;
  endtask

  task automatic drain();
    int t = 0;
    while (exp_q.size() > 0 && t < 200) begin
      @(posedge clk);
      t++;
    end
    if (exp_q.size() > 0) chk("drain_timeout", exp_q.size(), 0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    // 1: reset values, then idle frames
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_grant", int'(grant), 0);
    chk("rst_mode", int'(cur_mode), 0);
    chk("rst_tick", int'(frame_tick), 0);
    chk("rst_led", int'(led_out), 0);
    @(posedge clk); #2;
    rst_n = 1'b1;
    for (int f = 1; f <= 3; f++) push(f, 3'b000, 2'd0, 0);

    // 2: req[0] ON mid-frame
    wait_frame(3); mid_frame();
    set_req(0, 1'b1, 2'd1);
    for (int f = 4; f <= 6; f++) push(f, 3'b001, 2'd1, 32);

    // 3: switch to BREATH, full triangle
    wait_frame(6); mid_frame();
    set_req(0, 1'b1, 2'd3);
    for (int j = 0; j < 32; j++) push(7 + j, 3'b001, 2'd3, 2 * breath_exp[j]);

    // release, then fresh ON grant so hold starts at 0
    wait_frame(38); mid_frame();
    set_req(0, 1'b0, 2'd1);
    push(39, 3'b000, 2'd0, 0);
    wait_frame(39); mid_frame();
    set_req(0, 1'b1, 2'd1);
    push(40, 3'b001, 2'd1, 32);

    // 4: req[2] BLINK raised at hold 0, preempts after the hold time
    wait_frame(40); mid_frame();
    set_req(2, 1'b1, 2'd2);
    push(41, 3'b001, 2'd1, 32);
    push(42, 3'b001, 2'd1, 32);
    for (int f = 43; f <= 45; f++) push(f, 3'b100, 2'd2, 30);
    for (int f = 46; f <= 48; f++) push(f, 3'b100, 2'd2, 0);
    push(49, 3'b100, 2'd2, 30);

    // 5: req[1] waits behind req[2]; owner drop hands over to req[1]
    wait_frame(49); mid_frame();
    set_req(1, 1'b1, 2'd1);
    push(50, 3'b100, 2'd2, 30);
    push(51, 3'b100, 2'd2, 30);
    wait_frame(51); mid_frame();
    set_req(2, 1'b0, 2'd2);
    push(52, 3'b010, 2'd1, 32);
    push(53, 3'b010, 2'd1, 32);
    // release below hold time goes to req[0] immediately
    wait_frame(53); mid_frame();
    set_req(1, 1'b0, 2'd1);
    push(54, 3'b001, 2'd1, 32);
    // simultaneous owner drop and new higher request (OFF mode)
    wait_frame(54); mid_frame();
    set_req(0, 1'b0, 2'd1);
    set_req(2, 1'b1, 2'd0);
    push(55, 3'b100, 2'd0, 0);
    push(56, 3'b100, 2'd0, 0);

    // 6: BREATH on req[0], then reset pulse mid-pattern
    wait_frame(56); mid_frame();
    set_req(2, 1'b0, 2'd0);
    set_req(0, 1'b1, 2'd3);
    for (int f = 57; f <= 60; f++) push(f, 3'b001, 2'd3, 2 * (f - 57));
    wait_frame(61);
    drain();
    repeat (3) @(posedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    chk("async_rst_grant", int'(grant), 0);
    chk("async_rst_led", int'(led_out), 0);
    chk("async_rst_mode", int'(cur_mode), 0);
    for (int f = 1; f <= 4; f++) push(f, 3'b001, 2'd3, 2 * (f - 1));
    repeat (3) @(posedge clk);
    #2;
    rst_n = 1'b1;
    wait_frame(5);
    drain();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
